// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, in_class encoding and field widths shared with the Main_Decoder
package riscv_pkg;
  localparam int INSTR_W = 32;
  localparam int IMM_W = 21;
  localparam int REG_W = 5;
  localparam int CLASS_W = 3;
  localparam int F3_W = 3;
  typedef enum logic [CLASS_W-1:0] {
    CL_LOAD   = 3'd0,
    CL_STORE  = 3'd1,
    CL_RTYPE  = 3'd2,
    CL_BRANCH = 3'd3,
    CL_ITYPE  = 3'd4,
    CL_JAL    = 3'd5
  } in_class_e;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  function automatic logic class_legal(input logic [CLASS_W-1:0] c);
    return c <= CL_JAL;
  endfunction
  function automatic logic [6:0] opcode_of(input logic [CLASS_W-1:0] c);
    return c == CL_LOAD   ? OP_LOAD   :
           c == CL_STORE  ? OP_STORE  :
           c == CL_RTYPE  ? OP_RTYPE  :
           c == CL_BRANCH ? OP_BRANCH :
           c == CL_ITYPE  ? OP_ITYPE  :
           c == CL_JAL    ? OP_JAL    : 7'd0;
  endfunction
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-input and memory-write handshakes; err_imm exists only with INSTR_ENCODER_IMM_CHECK_EN
interface instr_encoder_if #(parameter int ADDR_W = 6);
  import riscv_pkg::*;
  logic                 in_valid;
  logic                 in_ready;
  logic [CLASS_W-1:0]   in_class;
  logic [REG_W-1:0]     rd;
  logic [REG_W-1:0]     rs1;
  logic [REG_W-1:0]     rs2;
  logic [F3_W-1:0]      funct3;
  logic                 funct7b5;
  logic [IMM_W-1:0]     imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [INSTR_W-1:0]   out_instr;
  logic [ADDR_W-1:0]    out_addr;
  logic                 err_class;
  logic [ADDR_W:0]      count;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
  logic                 err_imm;
  modport master (output in_valid, in_class, rd, rs1, rs2, funct3, funct7b5, imm, out_ready,
                  input in_ready, out_valid, out_instr, out_addr, err_class, count, err_imm);
  modport slave  (input in_valid, in_class, rd, rs1, rs2, funct3, funct7b5, imm, out_ready,
                  output in_ready, out_valid, out_instr, out_addr, err_class, count, err_imm);
`else
  modport master (output in_valid, in_class, rd, rs1, rs2, funct3, funct7b5, imm, out_ready,
                  input in_ready, out_valid, out_instr, out_addr, err_class, count);
  modport slave  (input in_valid, in_class, rd, rs1, rs2, funct3, funct7b5, imm, out_ready,
                  output in_ready, out_valid, out_instr, out_addr, err_class, count);
`endif
endinterface

// File: rtl/instr_encoder_imm_packer.sv
// imm_packer: scatters the two's-complement immediate into its RV32I bit positions per format
module imm_packer
  import riscv_pkg::*;
(
  input  logic [CLASS_W-1:0] in_class,
  input  logic [IMM_W-1:0]   imm,
  output logic [INSTR_W-1:0] imm_bits
);
  // I/S/B/J immediate layouts; R-type and illegal classes carry no immediate
  always_comb
    imm_bits = (in_class == CL_LOAD || in_class == CL_ITYPE) ? {imm[11:0], 20'd0} :
               in_class == CL_STORE  ? {imm[11:5], 13'd0, imm[4:0], 7'd0} :
               in_class == CL_BRANCH ? {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0} :
               in_class == CL_JAL    ? {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0} :
                                       '0;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction fields into RV32I words and streams them to sequential memory addresses; INSTR_ENCODER_IMM_CHECK_EN adds err_imm
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_encoder_if.slave bus
);
  logic [INSTR_W-1:0] imm_bits;
  logic [INSTR_W-1:0] word;
  logic in_fire;
  logic out_fire;
  logic legal;
  imm_packer u_imm (
    .in_class (bus.in_class),
    .imm      (bus.imm),
    .imm_bits (imm_bits)
  );
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign in_fire = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign legal = class_legal(bus.in_class);
  // Merge immediate with the register/funct fields each format uses; bit 30 is funct7b5 for R-type and ITYPE shifts
  always_comb begin
    logic use_rd, use_rs1, use_rs2, b30;
    use_rd  = !(bus.in_class == CL_STORE || bus.in_class == CL_BRANCH);
    use_rs1 = bus.in_class != CL_JAL;
    use_rs2 = bus.in_class == CL_STORE || bus.in_class == CL_RTYPE || bus.in_class == CL_BRANCH;
    b30 = (bus.in_class == CL_RTYPE || (bus.in_class == CL_ITYPE && bus.funct3 == 3'b101))
          ? bus.funct7b5 : imm_bits[30];
    word = {imm_bits[31], b30, imm_bits[29:0]} |
           {7'd0, use_rs2 ? bus.rs2 : 5'd0, use_rs1 ? bus.rs1 : 5'd0,
            use_rs1 ? bus.funct3 : 3'd0, use_rd ? bus.rd : 5'd0, opcode_of(bus.in_class)};
  end
  // Single output register: load on a legal input, advance address/count on each output transfer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_addr  <= '0;
      bus.count     <= '0;
      bus.err_class <= 1'b0;
    end else begin
      if (out_fire) begin
        bus.out_addr <= bus.out_addr + 1'b1;
        if (!bus.count[ADDR_W]) bus.count <= bus.count + 1'b1;
      end
      if (in_fire && legal) begin
        bus.out_valid <= 1'b1;
        bus.out_instr <= word;
      end else if (out_fire) bus.out_valid <= 1'b0;
      if (in_fire && !legal) bus.err_class <= 1'b1;
    end
`ifdef INSTR_ENCODER_IMM_CHECK_EN
  logic imm_fits;
  // Range test: upper bits must be a sign extension; B/J offsets must also be even
  always_comb
    imm_fits = (bus.in_class == CL_LOAD || bus.in_class == CL_STORE || bus.in_class == CL_ITYPE)
               ? bus.imm[20:11] == {10{bus.imm[11]}} :
               bus.in_class == CL_BRANCH ? (bus.imm[20:12] == {9{bus.imm[12]}} && !bus.imm[0]) :
               bus.in_class == CL_JAL    ? !bus.imm[0] : 1'b1;
  // Sticky flag for any accepted legal word whose immediate was truncated
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.err_imm <= 1'b0;
    else if (in_fire && legal && !imm_fits) bus.err_imm <= 1'b1;
`endif
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have a parameter ADDR_W, default 6, giving the instruction-memory word-address width.
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have a port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have in_valid (input, 1), in_ready (output, 1), in_class (input, 3), rd/rs1/rs2 (input, 5 each), funct3 (input, 3), funct7b5 (input, 1) and imm (input, 21, two's complement) as the field-input handshake.
REQ-005 The block SHALL have out_valid (output, 1), out_ready (input, 1), out_instr (output, 32) and out_addr (output, ADDR_W) as the memory-write handshake.
REQ-006 The block SHALL have err_class (output, 1, sticky) and count (output, ADDR_W+1: instructions emitted).

Function
REQ-007 in_class encodings SHALL be LOAD=0 (op 0000011), STORE=1 (0100011), RTYPE=2 (0110011), BRANCH=3 (1100011), ITYPE=4 (0010011), JAL=5 (1101111); values 6-7 are illegal.
REQ-008 Packing SHALL be standard RV32I: LOAD/ITYPE I-format imm[11:0]; STORE S-format; BRANCH B-format imm[12:1]; JAL J-format imm[20:1]; RTYPE funct7={0,funct7b5,00000}.
REQ-009 For ITYPE, instr[30] SHALL equal funct7b5 only when funct3=101; otherwise imm[11:0] is packed unchanged.
REQ-010 Fields a format does not use SHALL be ignored (e.g. rd for STORE/BRANCH, rs1/rs2 for JAL).
REQ-011 A transfer SHALL occur when in_valid && in_ready on a rising edge; the packed word SHALL appear on out_instr with out_valid=1 one cycle later (latency 1).
REQ-012 in_ready SHALL equal !out_valid || out_ready (single output register, full throughput, no combinational path from in_valid to in_ready).
REQ-013 out_instr/out_addr SHALL hold stable while out_valid && !out_ready.
REQ-014 On an output transfer (out_valid && out_ready), out_addr SHALL increment by 1 modulo 2^ADDR_W, and count SHALL increment, saturating at 2^ADDR_W.
REQ-015 On simultaneous output transfer and input transfer, out_valid SHALL remain 1 with the new word at the incremented address.
REQ-016 An illegal in_class SHALL be accepted (in_ready unaffected), produce no output word, leave out_addr unchanged and set err_class until reset.

Reset
REQ-017 rst_n low SHALL immediately force out_valid=0, out_instr=0, out_addr=0, count=0, err_class=0, abandoning any pending word.
REQ-018 The first accepted input after rst_n rises SHALL be emitted at out_addr=0.

Configuration
REQ-019 With INSTR_ENCODER_IMM_CHECK_EN defined, the block SHALL add output err_imm (sticky, reset 0), set when imm does not fit the format (I/S: -2048..2047; B: -4096..4094, even; J: -1048576..1048574, even), and SHALL still emit the truncated word.
REQ-020 Without INSTR_ENCODER_IMM_CHECK_EN, err_imm and its logic SHALL be absent and imm SHALL be truncated silently.

Structure
REQ-021 Opcode constants, the in_class encoding and format widths SHALL live in shared package riscv_pkg, shared with the Main_Decoder.
REQ-022 Immediate packing SHALL be a combinational sub-module imm_packer (in_class, imm -> 32-bit immediate bit-field mask).

Verification
REQ-023 LOAD rd=6, rs1=9, funct3=010, imm=-4 -> out_instr=0xFFC4A303 at out_addr=0, one cycle later.
REQ-024 STORE rs2=6, rs1=9, funct3=010, imm=8 -> 0x0064A423 at out_addr=1; RTYPE rd=4, rs1=5, rs2=6, funct3=000, funct7b5=0 -> 0x00628233 at out_addr=2.
REQ-025 JAL rd=1, imm=8 -> 0x008000EF; hold out_ready=0 for 3 cycles -> in_ready=0 and out_instr stable, then one transfer, count+1.
REQ-026 in_class=7 -> no out_valid pulse, err_class=1, out_addr unchanged; next legal input is emitted at the unchanged address.
REQ-027 Emit 2^ADDR_W+1 words back-to-back with out_ready=1 -> out_addr wraps to 0, count saturates at 64; assert rst_n low mid-stall -> out_valid drops immediately.
REQ-028 With INSTR_ENCODER_IMM_CHECK_EN, BRANCH imm=4095 -> err_imm=1; ITYPE imm=2047 -> err_imm stays 0.
